flag_register_unit: RTL and testbench

//  Producer side of the branch-condition flags. Samples the EX-stage ALU result and

---
 rtl/flag_register_unit.sv | 161 ++++++++++++++++
 tb/tb_flag_register_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flag_register_unit.sv
// Branch-condition flag producer: derives {Z,V,N} from the EX-stage ALU result,
// holds them in a 3-bit register, and raises the decode branch stall on a flag RAW.
// Optional build macro FLAG_FWD_EN: same-cycle flag bypass to decode, stall tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no flag write in flight toward a stalled branch
// HOLD  | branch stalled last cycle; the flag write lands this cycle
module flag_register_unit #(
    parameter int         DW        = 16,
    parameter logic [2:0] RST_FLAGS = 3'b000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovfl,
    input  logic          pipe_stall,
    input  logic          ex_flush,
    input  logic          br_in_id,
    output logic [2:0]    flags_out,
    output logic          br_stall,
    output logic          flag_wr
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    // Bit positions inside the packed {Z,V,N} word.
    localparam int BIT_Z = 2;
    localparam int BIT_V = 1;
    localparam int BIT_N = 0;

    typedef enum logic [1:0] {
        WC_NONE,
        WC_ZVN,
        WC_Z
    } wclass_e;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] flag_q, flag_d;
    logic       flag_wr_q, flag_wr_d;

    wclass_e    wclass;
    logic [2:0] wmask;
    logic [2:0] flag_new;
    logic       setter;
    logic       we;
    logic       haz;
    logic       br_stall_fsm;

    always_comb begin
        wclass = WC_NONE;
        unique case (ex_opcode)
            OP_ADD, OP_SUB:                 wclass = WC_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: wclass = WC_Z;
            default:                        wclass = WC_NONE;
        endcase
    end

    always_comb begin
        wmask = 3'b000;
        case (wclass)
            WC_ZVN:  wmask = 3'b111;
            WC_Z:    wmask = 3'b100;
            default: wmask = 3'b000;
        endcase
    end

    always_comb begin
        flag_new        = 3'b000;
        flag_new[BIT_Z] = (alu_result == '0);
        flag_new[BIT_V] = alu_ovfl;
        flag_new[BIT_N] = alu_result[DW-1];
    end

    assign setter = (wclass != WC_NONE);
    assign we     = ex_valid & ~pipe_stall & ~ex_flush & setter;
    // The hazard ignores pipe_stall so the stall persists for the whole EX hold.
    assign haz    = br_in_id & ex_valid & ~ex_flush & setter;

    always_comb begin
        flag_d    = flag_q;
        flag_wr_d = we;
        if (we) begin
            flag_d = (flag_q & ~wmask) | (flag_new & wmask);
        end
    end

    always_comb begin
        state_d      = state_q;
        br_stall_fsm = 1'b0;
        case (state_q)
            IDLE: begin
                br_stall_fsm = haz;
                if (haz && !pipe_stall) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                br_stall_fsm = haz;
                state_d      = (haz && !pipe_stall) ? HOLD : IDLE;
            end
            default: begin
                state_d      = IDLE;
                br_stall_fsm = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= RST_FLAGS;
            flag_wr_q <= 1'b0;
        end else begin
            flag_q    <= flag_d;
            flag_wr_q <= flag_wr_d;
        end
    end

`ifdef FLAG_FWD_EN
    // Bypass: decode sees the merged value in the same cycle, so no stall is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= IDLE;
        end
    end

    assign flags_out = flag_d;
    assign br_stall  = 1'b0;

    logic unused_fsm;
    assign unused_fsm = br_stall_fsm ^ (state_d == HOLD) ^ (state_q == HOLD);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign flags_out = flag_q;
    assign br_stall  = br_stall_fsm;
`endif

    assign flag_wr = flag_wr_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed-vector bench for flag_register_unit; expected values hand-computed.
// Expectations for decode-visible flags/stall follow the FLAG_FWD_EN build macro.
`timescale 1ns/1ps
module tb_flag_register_unit;

    localparam int DW = 16;

`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] XOR = 4'b0010;
    localparam logic [3:0] SRA = 4'b0101;
    localparam logic [3:0] ROR = 4'b0110;
    localparam logic [3:0] PADDSB = 4'b0111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] alu_result;
    logic          alu_ovfl;
    logic          pipe_stall;
    logic          ex_flush;
    logic          br_in_id;
    logic [2:0]    flags_out;
    logic          br_stall;
    logic          flag_wr;

    int n_vec = 0;
    int n_err = 0;

    flag_register_unit #(.DW(DW), .RST_FLAGS(3'b000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .alu_result (alu_result),
        .alu_ovfl   (alu_ovfl),
        .pipe_stall (pipe_stall),
        .ex_flush   (ex_flush),
        .br_in_id   (br_in_id),
        .flags_out  (flags_out),
        .br_stall   (br_stall),
        .flag_wr    (flag_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [DW-1:0] res,
                         input logic ov, input logic st, input logic fl, input logic br);
        ex_valid   = v;
        ex_opcode  = op;
        alu_result = res;
        alu_ovfl   = ov;
        pipe_stall = st;
        ex_flush   = fl;
        br_in_id   = br;
    endtask

    task automatic idle(input logic br);
        drive(1'b0, 4'b1111, '0, 1'b0, 1'b0, 1'b0, br);
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction for one cycle, then idle EX and check the registered result.
    task automatic op1(input string tag, input logic [3:0] op, input logic [DW-1:0] res,
                       input logic ov, input logic [2:0] exp_flags, input logic exp_wr);
        drive(1'b1, op, res, ov, 1'b0, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        #1;
        chk({tag, "_flags"}, {5'd0, flags_out}, {5'd0, exp_flags});
        chk({tag, "_wr"}, {7'd0, flag_wr}, {7'd0, exp_wr});
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        #3;
        chk("rst_flags", {5'd0, flags_out}, 8'h00);
        chk("rst_stall", {7'd0, br_stall}, 8'h00);
        chk("rst_wr", {7'd0, flag_wr}, 8'h00);
        #9 rst_n = 1'b1;
        tick();

        op1("add0", ADD, 16'h0000, 1'b0, 3'b100, 1'b1);
        op1("sub8000", SUB, 16'h8000, 1'b1, 3'b011, 1'b1);
        op1("xor0", XOR, 16'h0000, 1'b0, 3'b111, 1'b1);
        op1("paddsb", PADDSB, 16'h0000, 1'b1, 3'b111, 1'b0);

        // ex_valid low: no write even for a flag setter
        drive(1'b0, ADD, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        #1;
        chk("novalid_flags", {5'd0, flags_out}, 8'h07);

        // Async reset mid-cycle with a write pending
        op1("sub_pre_rst", SUB, 16'h8000, 1'b1, 3'b011, 1'b1);
        drive(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_flags", {5'd0, flags_out}, 8'h00);
        chk("async_wr", {7'd0, flag_wr}, 8'h00);
        tick();
        idle(1'b0);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_cancel", {5'd0, flags_out}, 8'h00);
        tick();

        // RAW hazard: SUB result 0 in EX, branch in decode
        drive(1'b1, SUB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("haz_stall", {7'd0, br_stall}, FWD ? 8'h00 : 8'h01);
        chk("haz_flags", {5'd0, flags_out}, FWD ? 8'h04 : 8'h00);
        tick();
        idle(1'b1);
        #1;
        chk("haz_release", {7'd0, br_stall}, 8'h00);
        chk("haz_flags2", {5'd0, flags_out}, 8'h04);
        idle(1'b0);

        op1("add7fff", ADD, 16'h7FFF, 1'b0, 3'b000, 1'b1);

        // Flush with a branch waiting: no write, no stall
        drive(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flush_stall", {7'd0, br_stall}, 8'h00);
        chk("flush_out", {5'd0, flags_out}, 8'h00);
        tick();
        idle(1'b0);
        #1;
        chk("flush_flags", {5'd0, flags_out}, 8'h00);
        chk("flush_wr", {7'd0, flag_wr}, 8'h00);

        // pipe_stall for 3 cycles holds the write back; branch stall follows haz
        drive(1'b1, ADD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("pstall_br%0d", i), {7'd0, br_stall}, FWD ? 8'h00 : 8'h01);
            chk($sformatf("pstall_fl%0d", i), {5'd0, flags_out}, 8'h00);
            tick();
            chk($sformatf("pstall_wr%0d", i), {7'd0, flag_wr}, 8'h00);
        end
        pipe_stall = 1'b0;
        br_in_id   = 1'b0;
        tick();
        idle(1'b0);
        #1;
        chk("pstall_land", {5'd0, flags_out}, 8'h04);
        chk("pstall_wr", {7'd0, flag_wr}, 8'h01);

        // Z-only writers keep V,N
        op1("sra8000", SRA, 16'h8000, 1'b1, 3'b000, 1'b1);
        op1("sub_vn", SUB, 16'h8000, 1'b1, 3'b011, 1'b1);
        op1("ror0", ROR, 16'h0000, 1'b0, 3'b111, 1'b1);

        // Back-to-back setters, each followed by a branch
        drive(1'b1, ADD, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("b2b_stall1", {7'd0, br_stall}, FWD ? 8'h00 : 8'h01);
        tick();
        idle(1'b1);
        #1;
        chk("b2b_rel1", {7'd0, br_stall}, 8'h00);
        chk("b2b_fl1", {5'd0, flags_out}, 8'h00);
        drive(1'b1, SUB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("b2b_stall2", {7'd0, br_stall}, FWD ? 8'h00 : 8'h01);
        tick();
        idle(1'b1);
        #1;
        chk("b2b_rel2", {7'd0, br_stall}, 8'h00);
        chk("b2b_fl2", {5'd0, flags_out}, 8'h04);
        idle(1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
